frogg_game_ctrl: RTL and testbench
==================================

FROGG_GAME_CTRL -- requirements
Module: frogg_game_ctrl

Interface
REQ-001 SHALL have parameter c_HOP_CYCLES, default 2550000, minimum clock cycles between successive hop grants.
REQ-002 SHALL have parameter c_HIT_CYCLES, default 25000000, freeze duration after a collision, in cycles.
REQ-003 SHALL have parameter c_LIVES, default 3, lives loaded at game start (range 1..3).
REQ-004 SHALL have parameter c_MAX_LEVEL, default 7, saturation value of o_Level.
REQ-005 SHALL have port i_Clk  input  1  sole clock; every register updates on its rising edge.
REQ-006 SHALL have port i_Rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_Start  input  1  level; starts a game from IDLE or OVER.
REQ-008 SHALL have port i_Dir  input  4  raw direction buttons {up,dn,lt,rt}, bit3=up.
REQ-009 SHALL have port i_Frog_Y  input  10  current frog row position in pixels; 0 = top (goal) row.
REQ-010 SHALL have port i_Collision  input  1  level; frog overlaps a hazard.
REQ-011 SHALL have port o_Hop_Grant  output  1  one-cycle pulse; frog datapath moves one 32-pixel step.
REQ-012 SHALL have port o_Hop_Dir  output  4  one-hot direction, valid while o_Hop_Grant=1, else 0.
REQ-013 SHALL have port o_Frog_Respawn  output  1  one-cycle pulse; datapath returns frog to start position.
REQ-014 SHALL have port o_State  output  3  state code: IDLE=0, PLAY=1, HIT=2, LEVEL=3, OVER=4.
REQ-015 SHALL have port o_Lives  output  2  remaining lives.
REQ-016 SHALL have port o_Level  output  3  current level.
REQ-017 SHALL have port o_Score  output  8  goal-row arrivals this game.
REQ-018 SHALL have port o_Game_Over  output  1  high exactly while state=OVER.

Function
REQ-019 All outputs SHALL be registered; every response below appears on the cycle after the causing input is sampled.
REQ-020 IDLE/OVER with i_Start=1: SHALL load o_Lives=c_LIVES, o_Score=0, o_Level=0, clear hop cooldown, pulse o_Frog_Respawn, enter PLAY.
REQ-021 i_Start SHALL be ignored in PLAY, HIT, LEVEL.
REQ-022 PLAY priority per cycle: i_Collision, then i_Frog_Y==0, then hop request; only the highest applies.
REQ-023 PLAY, i_Collision=1: SHALL decrement o_Lives (saturate at 0), load freeze timer with c_HIT_CYCLES-1, enter HIT, no grant.
REQ-024 PLAY, i_Frog_Y==0, no collision: SHALL increment o_Score (saturate 255), increment o_Level (saturate c_MAX_LEVEL), pulse o_Frog_Respawn, enter LEVEL.
REQ-025 Hop request valid only when exactly one i_Dir bit is set; zero or multiple bits SHALL produce no grant.
REQ-026 PLAY, valid request, cooldown=0: SHALL pulse o_Hop_Grant with o_Hop_Dir=i_Dir, load cooldown with c_HOP_CYCLES-1.
REQ-027 Cooldown SHALL decrement by 1 each cycle while nonzero regardless of i_Dir; held button yields one grant every c_HOP_CYCLES cycles.
REQ-028 No grant SHALL be issued outside PLAY; cooldown SHALL be cleared on every entry to PLAY.
REQ-029 HIT: timer decrements each cycle; at 0, o_Lives==0 -> OVER; else pulse o_Frog_Respawn, enter PLAY.
REQ-030 HIT SHALL ignore i_Collision, i_Dir, i_Frog_Y.
REQ-031 LEVEL SHALL remain until i_Frog_Y!=0, then enter PLAY; no grants, no further score increments.
REQ-032 OVER SHALL hold o_Lives, o_Score, o_Level frozen until i_Start.
REQ-033 Timer and cooldown counters SHALL be 32-bit unsigned, no wrap (stop at 0).
REQ-034 Undefined state codes 5..7 SHALL transition to IDLE next cycle.

Reset
REQ-035 i_Rst=1 SHALL on the next edge force state IDLE, all outputs 0, timer and cooldown 0, overriding all other inputs.
REQ-036 Reset asserted mid-HIT, LEVEL or cooldown SHALL abandon the operation; no respawn or grant pulse follows reset release without a new i_Start.

Verification (c_HOP_CYCLES=4, c_HIT_CYCLES=8, c_LIVES=3, c_MAX_LEVEL=7)
REQ-037 Reset, i_Start pulse -> o_State 0->1, o_Lives=3, o_Score=0, one o_Frog_Respawn pulse.
REQ-038 PLAY, i_Dir=1000 held 12 cycles -> grants at cycles 1,5,9, o_Hop_Dir=1000; i_Dir=1010 -> no grant.
REQ-039 PLAY, i_Collision and i_Dir=0100 same cycle -> no grant, o_Lives 3->2, HIT 8 cycles, respawn pulse, PLAY.
REQ-040 Three collisions -> o_Lives=0, after 8 HIT cycles o_State=4, o_Game_Over=1, i_Start restarts with o_Lives=3.
REQ-041 i_Frog_Y=0 eight times -> o_Score=8, o_Level=7 (saturated), LEVEL held until i_Frog_Y=448.
REQ-042 i_Rst at HIT cycle 3 -> IDLE, all outputs 0, no respawn pulse after release.

Source files
------------

// File: rtl/frogg_game_ctrl_if.sv
//------------------------------------------------------------------------------
// frogg_game_ctrl_if : control/status bundle between game logic and frog datapath
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface frogg_game_ctrl_if;
  logic       i_Start;
  logic [3:0] i_Dir;
  logic [9:0] i_Frog_Y;
  logic       i_Collision;
  logic       o_Hop_Grant;
  logic [3:0] o_Hop_Dir;
  logic       o_Frog_Respawn;
  logic [2:0] o_State;
  logic [1:0] o_Lives;
  logic [2:0] o_Level;
  logic [7:0] o_Score;
  logic       o_Game_Over;

  modport master (
    output i_Start, i_Dir, i_Frog_Y, i_Collision,
    input  o_Hop_Grant, o_Hop_Dir, o_Frog_Respawn, o_State,
    input  o_Lives, o_Level, o_Score, o_Game_Over
  );

  modport slave (
    input  i_Start, i_Dir, i_Frog_Y, i_Collision,
    output o_Hop_Grant, o_Hop_Dir, o_Frog_Respawn, o_State,
    output o_Lives, o_Level, o_Score, o_Game_Over
  );
endinterface

`default_nettype wire

// File: rtl/frogg_game_ctrl.sv
//------------------------------------------------------------------------------
// frogg_game_ctrl : frogger game FSM - hop pacing, collisions, lives, score, levels
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frogg_game_ctrl #(
  parameter int c_HOP_CYCLES = 2550000,
  parameter int c_HIT_CYCLES = 25000000,
  parameter int c_LIVES      = 3,
  parameter int c_MAX_LEVEL  = 7
) (
  input wire               i_Clk,
  input wire               i_Rst,
  frogg_game_ctrl_if.slave bus
);

  localparam logic [31:0] c_HOP_LOAD   = 32'(c_HOP_CYCLES - 1);
  localparam logic [31:0] c_HIT_LOAD   = 32'(c_HIT_CYCLES - 1);
  localparam logic [1:0]  c_LIVES_INIT = 2'(c_LIVES);
  localparam logic [2:0]  c_LEVEL_SAT  = 3'(c_MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_HIT   = 3'd2,
    S_LEVEL = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_timer;
  logic [31:0] r_cooldown;
  logic        r_hop_grant;
  logic [3:0]  r_hop_dir;
  logic        r_respawn;
  logic [1:0]  r_lives;
  logic [2:0]  r_level;
  logic [7:0]  r_score;
  logic        r_game_over;

  // A hop request is only honoured when exactly one button is pressed.
  logic w_hop_req;
  assign w_hop_req = (bus.i_Dir != 4'd0) && ((bus.i_Dir & (bus.i_Dir - 4'd1)) == 4'd0);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state     <= S_IDLE;
      r_timer     <= 32'd0;
      r_cooldown  <= 32'd0;
      r_hop_grant <= 1'b0;
      r_hop_dir   <= 4'd0;
      r_respawn   <= 1'b0;
      r_lives     <= 2'd0;
      r_level     <= 3'd0;
      r_score     <= 8'd0;
      r_game_over <= 1'b0;
    end else begin
      r_hop_grant <= 1'b0;
      r_hop_dir   <= 4'd0;
      r_respawn   <= 1'b0;
      if (r_cooldown != 32'd0)
        r_cooldown <= r_cooldown - 32'd1;

      case (r_state)
        S_IDLE, S_OVER: begin
          if (bus.i_Start) begin
            r_lives     <= c_LIVES_INIT;
            r_score     <= 8'd0;
            r_level     <= 3'd0;
            r_cooldown  <= 32'd0;
            r_respawn   <= 1'b1;
            r_game_over <= 1'b0;
            r_state     <= S_PLAY;
          end
        end

        S_PLAY: begin
          if (bus.i_Collision) begin
            if (r_lives != 2'd0)
              r_lives <= r_lives - 2'd1;
            r_timer <= c_HIT_LOAD;
            r_state <= S_HIT;
          end else if (bus.i_Frog_Y == 10'd0) begin
            if (r_score != 8'hFF)
              r_score <= r_score + 8'd1;
            if (r_level < c_LEVEL_SAT)
              r_level <= r_level + 3'd1;
            r_respawn <= 1'b1;
            r_state   <= S_LEVEL;
          end else if (w_hop_req && (r_cooldown == 32'd0)) begin
            r_hop_grant <= 1'b1;
            r_hop_dir   <= bus.i_Dir;
            r_cooldown  <= c_HOP_LOAD;
          end
        end

        S_HIT: begin
          if (r_timer == 32'd0) begin
            if (r_lives == 2'd0) begin
              r_game_over <= 1'b1;
              r_state     <= S_OVER;
            end else begin
              r_respawn  <= 1'b1;
              r_cooldown <= 32'd0;
              r_state    <= S_PLAY;
            end
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end

        S_LEVEL: begin
          // Wait for the datapath to move the frog off the goal row.
          if (bus.i_Frog_Y != 10'd0) begin
            r_cooldown <= 32'd0;
            r_state    <= S_PLAY;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_Hop_Grant    = r_hop_grant;
  assign bus.o_Hop_Dir      = r_hop_dir;
  assign bus.o_Frog_Respawn = r_respawn;
  assign bus.o_State        = r_state;
  assign bus.o_Lives        = r_lives;
  assign bus.o_Level        = r_level;
  assign bus.o_Score        = r_score;
  assign bus.o_Game_Over    = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_frogg_game_ctrl.sv
//------------------------------------------------------------------------------
// tb_frogg_game_ctrl : vector table plus multi-cycle sequences for frogg_game_ctrl
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_frogg_game_ctrl;

  localparam int c_HOP = 4;
  localparam int c_HIT = 8;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b1;

  frogg_game_ctrl_if bus ();

  frogg_game_ctrl #(
    .c_HOP_CYCLES (c_HOP),
    .c_HIT_CYCLES (c_HIT),
    .c_LIVES      (3),
    .c_MAX_LEVEL  (7)
  ) dut (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .bus   (bus.slave)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] lives;
    logic [2:0] lvl;
    logic [7:0] score;
    logic       grant;
    logic [3:0] dir;
    logic       resp;
    logic       over;
  } exp_t;

  typedef struct {
    logic       start;
    logic [3:0] dir;
    logic [9:0] y;
    logic       coll;
    exp_t       e;
    string      name;
  } vec_t;

  exp_t  q_exp[$];
  string q_name[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic exp_t mk(input logic [2:0] st, input logic [1:0] lives,
                              input logic [2:0] lvl, input logic [7:0] score,
                              input logic grant, input logic [3:0] dir,
                              input logic resp, input logic over);
    exp_t e;
    e = '{st, lives, lvl, score, grant, dir, resp, over};
    return e;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, check the registered response.
  task automatic apply(input logic s, input logic [3:0] d, input logic [9:0] y,
                       input logic c, input exp_t e, input string nm);
    exp_t got, want;
    string wn;
    bus.i_Start     = s;
    bus.i_Dir       = d;
    bus.i_Frog_Y    = y;
    bus.i_Collision = c;
    q_exp.push_back(e);
    q_name.push_back(nm);
    @(posedge i_Clk);
    #1;
    got  = {bus.o_State, bus.o_Lives, bus.o_Level, bus.o_Score, bus.o_Hop_Grant,
            bus.o_Hop_Dir, bus.o_Frog_Respawn, bus.o_Game_Over};
    want = q_exp.pop_front();
    wn   = q_name.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got st=%0d lives=%0d lvl=%0d score=%0d grant=%0b dir=%b resp=%0b over=%0b, want st=%0d lives=%0d lvl=%0d score=%0d grant=%0b dir=%b resp=%0b over=%0b",
               wn, got.st, got.lives, got.lvl, got.score, got.grant, got.dir, got.resp, got.over,
               want.st, want.lives, want.lvl, want.score, want.grant, want.dir, want.resp, want.over);
    end
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 4'b0000, 10'd100, 1'b0, mk(0,0,0,0,0,4'b0000,0,0), "idle_hold"};
    vecs[1]  = '{1'b1, 4'b0000, 10'd100, 1'b0, mk(1,3,0,0,0,4'b0000,1,0), "start"};
    vecs[2]  = '{1'b1, 4'b0000, 10'd100, 1'b0, mk(1,3,0,0,0,4'b0000,0,0), "start_ignored"};
    vecs[3]  = '{1'b0, 4'b1010, 10'd100, 1'b0, mk(1,3,0,0,0,4'b0000,0,0), "multi_dir"};
    vecs[4]  = '{1'b0, 4'b0001, 10'd100, 1'b0, mk(1,3,0,0,1,4'b0001,0,0), "hop_rt"};
    vecs[5]  = '{1'b0, 4'b0000, 10'd100, 1'b0, mk(1,3,0,0,0,4'b0000,0,0), "cd_idle"};
    vecs[6]  = '{1'b0, 4'b0010, 10'd100, 1'b0, mk(1,3,0,0,0,4'b0000,0,0), "cd_blocks"};
    vecs[7]  = '{1'b0, 4'b0000, 10'd100, 1'b0, mk(1,3,0,0,0,4'b0000,0,0), "cd_idle2"};
    vecs[8]  = '{1'b0, 4'b0100, 10'd100, 1'b0, mk(1,3,0,0,1,4'b0100,0,0), "hop_dn"};
    vecs[9]  = '{1'b0, 4'b0000, 10'd100, 1'b0, mk(1,3,0,0,0,4'b0000,0,0), "cd_a"};
    vecs[10] = '{1'b0, 4'b0000, 10'd100, 1'b0, mk(1,3,0,0,0,4'b0000,0,0), "cd_b"};
    vecs[11] = '{1'b0, 4'b0000, 10'd100, 1'b0, mk(1,3,0,0,0,4'b0000,0,0), "cd_c"};
    vecs[12] = '{1'b0, 4'b0100, 10'd100, 1'b1, mk(2,2,0,0,0,4'b0000,0,0), "coll_vs_hop"};

    bus.i_Start = 1'b0; bus.i_Dir = 4'd0; bus.i_Frog_Y = 10'd100; bus.i_Collision = 1'b0;

    i_Rst = 1'b1;
    apply(1'b1, 4'b1000, 10'd100, 1'b1, mk(0,0,0,0,0,4'b0000,0,0), "reset_state");
    i_Rst = 1'b0;

    for (int i = 0; i < 13; i++)
      apply(vecs[i].start, vecs[i].dir, vecs[i].y, vecs[i].coll, vecs[i].e, vecs[i].name);

    // HIT lasts c_HIT cycles and ignores every input.
    for (int i = 0; i < c_HIT - 1; i++)
      apply(1'b1, 4'b1000, 10'd0, 1'b1, mk(2,2,0,0,0,4'b0000,0,0), "hit_frozen");
    apply(1'b0, 4'b0000, 10'd100, 1'b0, mk(1,2,0,0,0,4'b0000,1,0), "hit_respawn");

    // Held button: one grant every c_HOP cycles.
    for (int i = 0; i < 12; i++)
      apply(1'b0, 4'b1000, 10'd100, 1'b0,
            mk(1,2,0,0,(i % c_HOP) == 0,((i % c_HOP) == 0) ? 4'b1000 : 4'b0000,0,0), "held_hop");

    // Goal arrivals: level saturates at 7, LEVEL holds until the frog leaves row 0.
    for (int k = 1; k <= 8; k++) begin
      apply(1'b0, 4'b1000, 10'd0, 1'b0,
            mk(3,2,(k > 7) ? 3'd7 : 3'(k),8'(k),0,4'b0000,1,0), "goal");
      apply(1'b0, 4'b1000, 10'd0, 1'b0,
            mk(3,2,(k > 7) ? 3'd7 : 3'(k),8'(k),0,4'b0000,0,0), "level_hold");
      apply(1'b0, 4'b0000, 10'd448, 1'b0,
            mk(1,2,(k > 7) ? 3'd7 : 3'(k),8'(k),0,4'b0000,0,0), "level_exit");
    end

    // Remaining two lives lost -> OVER with frozen stats.
    apply(1'b0, 4'b0000, 10'd100, 1'b1, mk(2,1,7,8,0,4'b0000,0,0), "coll2");
    for (int i = 0; i < c_HIT - 1; i++)
      apply(1'b0, 4'b0000, 10'd100, 1'b0, mk(2,1,7,8,0,4'b0000,0,0), "hit2");
    apply(1'b0, 4'b0000, 10'd100, 1'b0, mk(1,1,7,8,0,4'b0000,1,0), "hit2_respawn");
    apply(1'b0, 4'b0000, 10'd100, 1'b1, mk(2,0,7,8,0,4'b0000,0,0), "coll3");
    for (int i = 0; i < c_HIT - 1; i++)
      apply(1'b0, 4'b0000, 10'd100, 1'b0, mk(2,0,7,8,0,4'b0000,0,0), "hit3");
    apply(1'b0, 4'b1000, 10'd0, 1'b1, mk(4,0,7,8,0,4'b0000,0,1), "game_over");
    apply(1'b0, 4'b1000, 10'd0, 1'b1, mk(4,0,7,8,0,4'b0000,0,1), "over_frozen");
    apply(1'b1, 4'b0000, 10'd100, 1'b0, mk(1,3,0,0,0,4'b0000,1,0), "restart");

    // Score saturates at 255.
    for (int k = 1; k <= 257; k++) begin
      apply(1'b0, 4'b0000, 10'd0, 1'b0,
            mk(3,3,(k > 7) ? 3'd7 : 3'(k),(k > 255) ? 8'd255 : 8'(k),0,4'b0000,1,0), "score_sat");
      apply(1'b0, 4'b0000, 10'd448, 1'b0,
            mk(1,3,(k > 7) ? 3'd7 : 3'(k),(k > 255) ? 8'd255 : 8'(k),0,4'b0000,0,0), "score_exit");
    end

    // Reset during HIT abandons the freeze; nothing pulses afterwards.
    apply(1'b0, 4'b0000, 10'd100, 1'b1, mk(2,2,7,255,0,4'b0000,0,0), "coll_pre_rst");
    apply(1'b0, 4'b0000, 10'd100, 1'b0, mk(2,2,7,255,0,4'b0000,0,0), "hit_c2");
    i_Rst = 1'b1;
    apply(1'b0, 4'b0000, 10'd100, 1'b0, mk(0,0,0,0,0,4'b0000,0,0), "rst_mid_hit");
    i_Rst = 1'b0;
    for (int i = 0; i < c_HIT + 2; i++)
      apply(1'b0, 4'b1000, 10'd100, 1'b0, mk(0,0,0,0,0,4'b0000,0,0), "post_rst_quiet");

    // Reset mid-cooldown: next game grants immediately.
    apply(1'b1, 4'b0000, 10'd100, 1'b0, mk(1,3,0,0,0,4'b0000,1,0), "start2");
    apply(1'b0, 4'b0010, 10'd100, 1'b0, mk(1,3,0,0,1,4'b0010,0,0), "hop_lt");
    i_Rst = 1'b1;
    apply(1'b0, 4'b0010, 10'd100, 1'b0, mk(0,0,0,0,0,4'b0000,0,0), "rst_mid_cd");
    i_Rst = 1'b0;
    apply(1'b1, 4'b0010, 10'd100, 1'b0, mk(1,3,0,0,0,4'b0000,1,0), "start3");
    apply(1'b0, 4'b0010, 10'd100, 1'b0, mk(1,3,0,0,1,4'b0010,0,0), "hop_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
